wishb_arbiter: RTL
==================

# wishb_arbiter

Two-master WISHBONE bus arbiter placed between the bus-master interfaces (processor port and DMA/secondary port) and the single shared WISHBONE slave (memory controller). Grants the bus to one master per WISHBONE cycle using round-robin priority. Holds the grant for the full `cyc` envelope, then routes the winner's address, data, and strobes to the slave and the slave's `ack` back only to the winner. An optional watchdog terminates cycles the slave never acknowledges.

## Interface
- `ADR_W`, default 26: address width.
- `DAT_W`, default 32: data width.
- `TIMEOUT`, default 15: watchdog limit in cycles. Used only with `WISHB_ARB_TIMEOUT_EN`. Legal range 2..255.

Ports:
- `clk_i`  in  1  Bus clock. All state updates on the rising edge.
- `rst_i`  in  1  Reset. Asynchronous, active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  Master 0 cycle, strobe, and write-enable.
- `m0_adr_i`  in  `ADR_W`  Master 0 address.
- `m0_dat_i`  in  `DAT_W`  Master 0 write data.
- `m0_ack_o`, `m0_err_o`  out  1 each  Master 0 acknowledge and error.
- `m1_*`: same set as master 0, for master 1.
- `m_dat_o`  out  `DAT_W`  Slave read data, broadcast to both masters.
- `cyc_o`, `stb_o`, `we_o`  out  1 each  To the slave.
- `adr_o`  out  `ADR_W`  To the slave.
- `dat_o`  out  `DAT_W`  To the slave.
- `dat_i`  in  `DAT_W`  From the slave.
- `ack_i`  in  1  From the slave.
- `gnt_o`  out  2  One-hot grant. Bit 0 is master 0, bit 1 is master 1.

## Operation
- **States:** IDLE, GNT0, GNT1. State is registered. `gnt_o` decodes the state directly: IDLE=00, GNT0=01, GNT1=10.
- **Priority pointer:** `last` records the most recently granted master. Reset value is 1, so master 0 wins the first contention.
- **IDLE:**
  - Only `m0_cyc_i` high -> GNT0.
  - Only `m1_cyc_i` high -> GNT1.
  - Both high -> grant the master that is not `last`.
  - Neither high -> stay in IDLE.
- **GNTx:**
  - Stay while `mx_cyc_i` is high.
  - When `mx_cyc_i` is low: if the other master's `cyc` is high, go directly to the other GNT (no idle cycle); otherwise go to IDLE.
  - `last` updates whenever a GNT state is entered.
- **Slave-side muxing (combinational from state):**
  - `cyc_o` = `gnt_o[0]&m0_cyc_i | gnt_o[1]&m1_cyc_i`.
  - `stb_o` follows the same pattern with the `stb` inputs.
  - `we_o`, `adr_o`, `dat_o` select the granted master's signals. They are 0 in IDLE.
- **Response routing:**
  - `mx_ack_o` = `ack_i & gnt_o[x] & mx_stb_i`.
  - `m_dat_o` = `dat_i`, unconditionally.
  - A non-granted master never sees `ack`.
- **Reset values** (immediate on `rst_i` low): state IDLE, `gnt_o`=00, `last`=1, every slave-side output 0, `mx_ack_o`=0, `mx_err_o`=0.
- **Reset mid-cycle:** the grant is lost asynchronously and `cyc_o`/`stb_o` fall in the same instant. No pending `ack` is forwarded.

## Timing
- **Grant latency:** one cycle. A request seen at edge N gives `gnt_o` and `cyc_o` valid after edge N.
- **Handover:** back-to-back. If master 0 drops `cyc` before edge N while master 1 is requesting, master 1 drives the slave after edge N.
- **Simultaneous release and request by the same master:** a master that drops `cyc` for at least one edge re-arbitrates. If the other master is requesting, the other master wins.
- **Ack path:** `ack_i` to `mx_ack_o` is combinational, with zero added latency. Block read/write bursts (`stb` held, several acks) pass through unchanged.
- **Grant hold:** the arbiter never preempts. A grant is held for as long as `cyc` stays high, subject only to the watchdog when it is enabled.

## Configuration
- **`WISHB_ARB_TIMEOUT_EN` defined:**
  - An 8-bit watchdog counter clears on any `ack_i` and on any state change.
  - It increments every cycle in which `stb_o`=1 and `ack_i`=0.
  - When the count equals `TIMEOUT`: the granted master gets a one-cycle `mx_err_o`, the counter clears, and the state goes to IDLE on the same edge. `cyc_o`/`stb_o` drop the following cycle.
  - If that master still holds `cyc`, it re-arbitrates normally.
- **`WISHB_ARB_TIMEOUT_EN` undefined:**
  - No counter.
  - `m0_err_o` and `m1_err_o` are tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- **Reset:** `rst_i`=0 asynchronously mid-cycle -> `gnt_o`=00, `cyc_o`=0, `stb_o`=0, `m0_ack_o`=0, without waiting for a clock edge.
- **Single master:**
  - Stimulus: master 1 writes `adr`=26'h0000A4, `dat`=32'hDEADBEEF; slave acks at cycle 3.
  - Response: `gnt_o`=10 one cycle after the request; `adr_o`/`dat_o` match; `we_o`=1; exactly one `m1_ack_o`; `m0_ack_o` stays 0.
- **Contention from reset:**
  - Stimulus: both `cyc` rise on the same edge.
  - Response: master 0 is granted first. After `m0_cyc_i` drops, `gnt_o`=10 on the next edge with no IDLE cycle. Repeating the contention then grants master 1 first only if `last`=0.
- **Round-robin fairness:** both masters issue 8 single reads continuously -> grants alternate 01,10,01,… and each master receives 8 acks.
- **Burst passthrough:** master 0 holds `cyc`/`stb` for 4 acks while master 1 requests -> master 1 is not granted until master 0 drops `cyc`. `m_dat_o` follows `dat_i` each ack.
- **Watchdog (macro on, `TIMEOUT`=15):** slave never acks a master 0 read -> `m0_err_o` pulses exactly once after the 15th unacked strobe cycle and state returns to IDLE. With the macro off, `cyc_o` stays high indefinitely.

Source files
------------

// File: rtl/wishb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wishb_arbiter
// Purpose  : Two-master WISHBONE arbiter in front of a single shared slave.
//            Round-robin grant per cyc envelope, no preemption, back-to-back
//            handover. The winner's request is routed to the slave, and the
//            slave's ack is routed back only to the winner.
// Ports    : clk_i, rst_i (async, active-low)
//            m0_* / m1_* : master cyc/stb/we/adr/dat in, ack/err out
//            m_dat_o     : slave read data broadcast to both masters
//            cyc_o, stb_o, we_o, adr_o, dat_o : request to the slave
//            dat_i, ack_i: slave response
//            gnt_o       : one-hot grant (bit0 = master 0, bit1 = master 1)
// Options  : WISHB_ARB_TIMEOUT_EN - when defined, an 8-bit watchdog ends a
//            cycle left unacknowledged for TIMEOUT strobe cycles and pulses
//            the owner's err. When undefined, err outputs are 0 and TIMEOUT
//            has no effect.
// Revision : 1.0 - initial release
// ============================================================================
module wishb_arbiter #(
  parameter int ADR_W   = 26,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m_dat_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             ack_i,
  output logic [1:0]       gnt_o
);

  // Encoding chosen so the state register is the one-hot grant itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   last_q;      // most recently granted master; 1 lets master 0 win first

`ifdef WISHB_ARB_TIMEOUT_EN
  localparam logic [7:0] WDT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wdt_q;
  logic       wdt_fire;
  logic       m0_err_q, m1_err_q;

  // Fires on the edge that would take the count to TIMEOUT.
  assign wdt_fire = stb_o & ~ack_i & (wdt_q == WDT_LAST);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0:    if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
      GNT1:    if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
`ifdef WISHB_ARB_TIMEOUT_EN
    // A timed-out owner goes back through IDLE to re-arbitrate.
    if (wdt_fire) state_d = IDLE;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d == GNT0 && state_q != GNT0) last_q <= 1'b0;
      if (state_d == GNT1 && state_q != GNT1) last_q <= 1'b1;
    end
  end

`ifdef WISHB_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wdt_q    <= 8'd0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else begin
      m0_err_q <= wdt_fire & (state_q == GNT0);
      m1_err_q <= wdt_fire & (state_q == GNT1);
      if (wdt_fire || ack_i || (state_d != state_q)) wdt_q <= 8'd0;
      else if (stb_o)                               wdt_q <= wdt_q + 8'd1;
    end
  end

  assign m0_err_o = m0_err_q;
  assign m1_err_o = m1_err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  assign gnt_o = state_q;

  // Slave-side mux: everything collapses to 0 in IDLE since gnt_o is 00.
  assign cyc_o = (gnt_o[0] & m0_cyc_i) | (gnt_o[1] & m1_cyc_i);
  assign stb_o = (gnt_o[0] & m0_stb_i) | (gnt_o[1] & m1_stb_i);
  assign we_o  = (gnt_o[0] & m0_we_i)  | (gnt_o[1] & m1_we_i);
  assign adr_o = ({ADR_W{gnt_o[0]}} & m0_adr_i) | ({ADR_W{gnt_o[1]}} & m1_adr_i);
  assign dat_o = ({DAT_W{gnt_o[0]}} & m0_dat_i) | ({DAT_W{gnt_o[1]}} & m1_dat_i);

  assign m0_ack_o = ack_i & gnt_o[0] & m0_stb_i;
  assign m1_ack_o = ack_i & gnt_o[1] & m1_stb_i;
  assign m_dat_o  = dat_i;

endmodule
`default_nettype wire
